// File: rtl/cpu_defs_pkg.sv
// Shared pipeline encodings: write-back source selects, load-extension types, branch op codes.
// Also holds the register-index width and the bundled write-back triple seen by the hazard unit.
package cpu_defs_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_LINK = 2'd2;

    localparam logic [3:0] LD_W  = 4'd0;
    localparam logic [3:0] LD_B  = 4'd1;
    localparam logic [3:0] LD_BU = 4'd2;
    localparam logic [3:0] LD_H  = 4'd3;
    localparam logic [3:0] LD_HU = 4'd4;

    // Conditional-link branch (bgezal/bltzal style): link only when the compare is taken.
    localparam logic [5:0] BOP_CLINK = 6'd9;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] a3;
        logic [XLEN-1:0]      data;
    } wb_t;

    function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc_add4);
        return pc_add4 + XLEN'(4);
    endfunction

endpackage

// File: rtl/wb_stage_grf_load_ext.sv
// Load extension: picks byte/halfword at the address offset and sign/zero-extends it.
// Purely combinational, no state; never stalls.
module load_ext
    import cpu_defs_pkg::*;
(
    input  logic [XLEN-1:0] i_dm_data,
    input  logic [1:0]      i_offset,
    input  logic [3:0]      i_md_op,
    output logic [XLEN-1:0] o_ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_dm_data[7:0];
        case (i_offset)
            2'd1:    w_byte = i_dm_data[15:8];
            2'd2:    w_byte = i_dm_data[23:16];
            2'd3:    w_byte = i_dm_data[31:24];
            default: w_byte = i_dm_data[7:0];
        endcase
    end

    assign w_half = i_offset[1] ? i_dm_data[31:16] : i_dm_data[15:0];

    // Unlisted encodings fall through to a plain word load.
    always_comb begin
        o_ext_data = i_dm_data;
        case (i_md_op)
            LD_B:    o_ext_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_ext_data = {24'd0, w_byte};
            LD_H:    o_ext_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_ext_data = {16'd0, w_half};
            default: o_ext_data = i_dm_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_grf.sv
// Write-back stage + 32x32 GRF: combinational WB select/gating, write commits at posedge, async reads.
// No backpressure; GRF_BYPASS_EN makes same-cycle WB data visible on the decode read ports.
module wb_stage_grf
    import cpu_defs_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int ZERO_REG = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Mem2Reg,
    input  logic                 RegWrite,
    input  logic [3:0]           mdOp,
    input  logic [XLEN-1:0]      dm_data,
    input  logic [REG_IDX_W-1:0] A3,
    input  logic [XLEN-1:0]      ALU_C,
    input  logic [XLEN-1:0]      pc_add4,
    input  logic                 cmp_check,
    input  logic [5:0]           bOp,
    input  logic [REG_IDX_W-1:0] A1,
    input  logic [REG_IDX_W-1:0] A2,
    output logic [XLEN-1:0]      RD1,
    output logic [XLEN-1:0]      RD2,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_a3,
    output logic [XLEN-1:0]      wb_data
);

    localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

    logic [XLEN-1:0] r_grf [REG_NUM];

    logic [XLEN-1:0] w_ext_data;
    logic [XLEN-1:0] w_data;
    logic            w_req;
    logic            w_we;
    wb_t             w_wb;

    load_ext u_load_ext (
        .i_dm_data  (dm_data),
        .i_offset   (ALU_C[1:0]),
        .i_md_op    (mdOp),
        .o_ext_data (w_ext_data)
    );

    // Reserved select value 3 behaves like the ALU path.
    always_comb begin
        w_data = ALU_C;
        case (Mem2Reg)
            M2R_MEM:  w_data = w_ext_data;
            M2R_LINK: w_data = link_addr(pc_add4);
            default:  w_data = ALU_C;
        endcase
    end

    assign w_req = (bOp == BOP_CLINK) ? (RegWrite & cmp_check) : RegWrite;
    assign w_we  = w_req & (A3 != ZERO_IDX) & reset;

    assign w_wb.we   = w_we;
    assign w_wb.a3   = w_we ? A3 : '0;
    assign w_wb.data = w_data;

    assign wb_we   = w_wb.we;
    assign wb_a3   = w_wb.a3;
    assign wb_data = w_wb.data;

    // Reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_grf[i] <= '0;
            end
        end else if (w_we) begin
            r_grf[A3] <= w_data;
        end
    end

`ifdef GRF_BYPASS_EN
    assign RD1 = (A1 == ZERO_IDX) ? '0 : ((w_we && (A1 == A3)) ? w_data : r_grf[A1]);
    assign RD2 = (A2 == ZERO_IDX) ? '0 : ((w_we && (A2 == A3)) ? w_data : r_grf[A2]);
`else
    assign RD1 = (A1 == ZERO_IDX) ? '0 : r_grf[A1];
    assign RD2 = (A2 == ZERO_IDX) ? '0 : r_grf[A2];
`endif

endmodule

// File: tb/tb_wb_stage_grf.sv
// Bench for wb_stage_grf: vector table through a scoreboard queue, plus same-cycle RAW and reset-between-writes sequences.
module tb_wb_stage_grf;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Mem2Reg;
    logic        RegWrite;
    logic [3:0]  mdOp;
    logic [31:0] dm_data;
    logic [4:0]  A3;
    logic [31:0] ALU_C;
    logic [31:0] pc_add4;
    logic        cmp_check;
    logic [5:0]  bOp;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_data;

    wb_stage_grf dut (
        .clk(clk), .reset(reset), .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .mdOp(mdOp),
        .dm_data(dm_data), .A3(A3), .ALU_C(ALU_C), .pc_add4(pc_add4), .cmp_check(cmp_check),
        .bOp(bOp), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  m2r;
        logic        rw;
        logic [3:0]  md;
        logic [31:0] dm;
        logic [4:0]  a3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        cmp;
        logic [5:0]  bop;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];
    vec_t        tbl [17];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input string nm, input logic rst, input logic [1:0] m2r, input logic rw,
                                input logic [3:0] md, input logic [31:0] dm, input logic [4:0] a3,
                                input logic [31:0] alu, input logic [31:0] pc4, input logic cmp,
                                input logic [5:0] bop, input logic ewe, input logic [4:0] ea3,
                                input logic [31:0] edat);
        vec_t v;
        v.name = nm; v.rst = rst; v.m2r = m2r; v.rw = rw; v.md = md; v.dm = dm; v.a3 = a3;
        v.alu = alu; v.pc4 = pc4; v.cmp = cmp; v.bop = bop;
        v.exp_we = ewe; v.exp_a3 = ea3; v.exp_data = edat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; Mem2Reg = v.m2r; RegWrite = v.rw; mdOp = v.md; dm_data = v.dm;
        A3 = v.a3; ALU_C = v.alu; pc_add4 = v.pc4; cmp_check = v.cmp; bOp = v.bop;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".wb_we"},   {31'd0, wb_we}, {31'd0, e.we});
            chk({e.name, ".wb_a3"},   {27'd0, wb_a3}, {27'd0, e.a3});
            chk({e.name, ".wb_data"}, wb_data,        e.data);
        end
    endtask

    // One full write-back cycle: drive, check the combinational triple, clock, then read back A3.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        A1 = v.a3;
        A2 = 5'd0;
        e.name = v.name; e.we = v.exp_we; e.a3 = v.exp_a3; e.data = v.exp_data;
        sb.push_back(e);
        #1;
        sb_check();
        @(posedge clk);
        if (!v.rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (v.exp_we) begin
            mdl[v.a3] = v.exp_data;
        end
        #1;
        chk({v.name, ".rd1_after"}, RD1, (v.a3 == 5'd0) ? 32'd0 : mdl[v.a3]);
        chk({v.name, ".rd2_zero"},  RD2, 32'd0);
    endtask

    vec_t        bub;
    vec_t        v;
    logic [31:0] raw_exp;

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        tbl[0]  = mk("rst_hold",   1'b0, 2'd0, 1'b1, 4'd0, 32'h0,         5'd5,  32'h55,        32'h0,         1'b0, 6'd0,      1'b0, 5'd0,  32'h55);
        tbl[1]  = mk("lb",         1'b1, 2'd1, 1'b1, 4'd1, 32'h8081_F2F3, 5'd3,  32'h1,         32'h0,         1'b0, 6'd0,      1'b1, 5'd3,  32'hFFFF_FFF2);
        tbl[2]  = mk("lbu",        1'b1, 2'd1, 1'b1, 4'd2, 32'h8081_F2F3, 5'd4,  32'h1,         32'h0,         1'b0, 6'd0,      1'b1, 5'd4,  32'h0000_00F2);
        tbl[3]  = mk("lh_hi",      1'b1, 2'd1, 1'b1, 4'd3, 32'h8081_F2F3, 5'd6,  32'h2,         32'h0,         1'b0, 6'd0,      1'b1, 5'd6,  32'hFFFF_8081);
        tbl[4]  = mk("lhu_lo",     1'b1, 2'd1, 1'b1, 4'd4, 32'h8081_F2F3, 5'd8,  32'h0,         32'h0,         1'b0, 6'd0,      1'b1, 5'd8,  32'h0000_F2F3);
        tbl[5]  = mk("lw",         1'b1, 2'd1, 1'b1, 4'd0, 32'h8081_F2F3, 5'd9,  32'h3,         32'h0,         1'b0, 6'd0,      1'b1, 5'd9,  32'h8081_F2F3);
        tbl[6]  = mk("md_rsvd",    1'b1, 2'd1, 1'b1, 4'd9, 32'h8081_F2F3, 5'd10, 32'h1,         32'h0,         1'b0, 6'd0,      1'b1, 5'd10, 32'h8081_F2F3);
        tbl[7]  = mk("lb_off3",    1'b1, 2'd1, 1'b1, 4'd1, 32'h8081_F2F3, 5'd11, 32'h3,         32'h0,         1'b0, 6'd0,      1'b1, 5'd11, 32'hFFFF_FF80);
        tbl[8]  = mk("link",       1'b1, 2'd2, 1'b1, 4'd0, 32'h0,         5'd31, 32'h0,         32'h0000_3004, 1'b0, 6'd0,      1'b1, 5'd31, 32'h0000_3008);
        tbl[9]  = mk("link_wrap",  1'b1, 2'd2, 1'b1, 4'd0, 32'h0,         5'd30, 32'h0,         32'hFFFF_FFFC, 1'b0, 6'd0,      1'b1, 5'd30, 32'h0000_0000);
        tbl[10] = mk("clink_nt",   1'b1, 2'd2, 1'b1, 4'd0, 32'h0,         5'd31, 32'h0,         32'h0000_0100, 1'b0, BOP_CLINK, 1'b0, 5'd0,  32'h0000_0104);
        tbl[11] = mk("clink_t",    1'b1, 2'd2, 1'b1, 4'd0, 32'h0,         5'd31, 32'h0,         32'h0000_0100, 1'b1, BOP_CLINK, 1'b1, 5'd31, 32'h0000_0104);
        tbl[12] = mk("m2r_rsvd",   1'b1, 2'd3, 1'b1, 4'd1, 32'hFFFF_FFFF, 5'd12, 32'hCAFE_0001, 32'h0000_2000, 1'b0, 6'd0,      1'b1, 5'd12, 32'hCAFE_0001);
        tbl[13] = mk("plain_cmp0", 1'b1, 2'd0, 1'b1, 4'd0, 32'h0,         5'd13, 32'h0000_0077, 32'h0,         1'b0, 6'd1,      1'b1, 5'd13, 32'h0000_0077);
        tbl[14] = mk("a3_zero",    1'b1, 2'd0, 1'b1, 4'd0, 32'h0,         5'd0,  32'h0000_1234, 32'h0,         1'b0, 6'd0,      1'b0, 5'd0,  32'h0000_1234);
        tbl[15] = mk("bubble",     1'b1, 2'd0, 1'b0, 4'd0, 32'h0,         5'd0,  32'h0,         32'h0,         1'b0, 6'd0,      1'b0, 5'd0,  32'h0);
        tbl[16] = mk("rw_off",     1'b1, 2'd0, 1'b0, 4'd0, 32'h0,         5'd14, 32'h0000_0099, 32'h0,         1'b0, 6'd0,      1'b0, 5'd0,  32'h0000_0099);

        bub = mk("bubble", 1'b0, 2'd0, 1'b0, 4'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'h0);
        drive(bub);
        A1 = 5'd0; A2 = 5'd0;
        repeat (2) @(posedge clk);

        // Every address reads zero straight out of reset.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_rd1[%0d]", i), RD1, 32'd0);
            chk($sformatf("reset_rd2[%0d]", 31 - i), RD2, 32'd0);
        end

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // Same-cycle write and read of reg7 on both ports.
        v = mk("pre7", 1'b1, 2'd0, 1'b1, 4'd0, 32'h0, 5'd7, 32'h1111_1111, 32'h0, 1'b0, 6'd0, 1'b1, 5'd7, 32'h1111_1111);
        apply(v);
        @(negedge clk);
        v = mk("raw7", 1'b1, 2'd0, 1'b1, 4'd0, 32'h0, 5'd7, 32'hDEAD_BEEF, 32'h0, 1'b0, 6'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        drive(v);
        A1 = 5'd7; A2 = 5'd7;
`ifdef GRF_BYPASS_EN
        raw_exp = 32'hDEAD_BEEF;
`else
        raw_exp = 32'h1111_1111;
`endif
        #1;
        chk("raw7.rd1_before", RD1, raw_exp);
        chk("raw7.rd2_before", RD2, raw_exp);
        @(posedge clk);
        #1;
        chk("raw7.rd1_after", RD1, 32'hDEAD_BEEF);
        chk("raw7.rd2_after", RD2, 32'hDEAD_BEEF);
        mdl[7] = 32'hDEAD_BEEF;

        // Reset between two writes: earlier write lost, write during reset dropped, later write commits.
        v = mk("w20", 1'b1, 2'd0, 1'b1, 4'd0, 32'h0, 5'd20, 32'h0000_AAAA, 32'h0, 1'b0, 6'd0, 1'b1, 5'd20, 32'h0000_AAAA);
        apply(v);
        v = mk("w21_in_rst", 1'b0, 2'd0, 1'b1, 4'd0, 32'h0, 5'd21, 32'h0000_BBBB, 32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'h0000_BBBB);
        apply(v);
        v = mk("w21_post", 1'b1, 2'd0, 1'b1, 4'd0, 32'h0, 5'd21, 32'h0000_CCCC, 32'h0, 1'b0, 6'd0, 1'b1, 5'd21, 32'h0000_CCCC);
        apply(v);
        @(negedge clk);
        drive(tbl[15]);
        A1 = 5'd20; A2 = 5'd7;
        #1;
        chk("rst_between.reg20", RD1, 32'd0);
        chk("rst_between.reg7",  RD2, 32'd0);
        A1 = 5'd21; A2 = 5'd21;
        #1;
        chk("rst_between.reg21_p1", RD1, 32'h0000_CCCC);
        chk("rst_between.reg21_p2", RD2, 32'h0000_CCCC);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
